// File: rtl/ic_line_fill.sv
// Instruction-cache line-fill read master: turns a one-cycle miss request into
// a single AXI4 INCR burst of four 32-bit beats and returns the 128-bit line
// with a one-cycle valid pulse. A pipeline reset mid-fill is absorbed by
// finishing the bus transaction and dropping the result.
module ic_line_fill #(
    parameter int unsigned       IDW      = 4,
    parameter logic [IDW-1:0]    ARID_VAL = IDW'(4'h1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 icr_start_rq,
    input  logic [31:0]          ic_rin_addr,
    input  logic                 rst_pipe,
    output logic                 ic_rdat_m_valid,
    output logic [127:0]         ic_rdat_m_data,
    output logic                 ic_finish_mrd,
    output logic                 ic_fill_busy,
    output logic                 ic_bus_err,
    output logic [IDW-1:0]       arid,
    output logic [31:0]          araddr,
    output logic [7:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [IDW-1:0]       rid,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [27:0]    addr_q, addr_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           abort_q, abort_d;
    logic           err_q, err_d;
    logic           drain_q, drain_d;
    logic [127:0]   line_q, line_d;

    // RID is not checked (single outstanding burst); low address bits are line offset.
    logic unused_inputs;
    assign unused_inputs = ^{rid, ic_rin_addr[3:0]};

    // Fixed burst shape: one 4-beat INCR burst of 32-bit words.
    assign arid    = ARID_VAL;
    assign arlen   = 8'd3;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign araddr  = {addr_q, 4'h0};
    assign ic_rdat_m_data = line_q;

    // State and datapath registers, all cleared by the asynchronous core reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            drain_q <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            drain_q <= drain_d;
            line_q  <= line_d;
        end
    end

    // Next-state, beat assembly and handshake/status outputs.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cnt_d           = cnt_q;
        abort_d         = abort_q;
        err_d           = err_q;
        drain_d         = drain_q;
        line_d          = line_q;
        arvalid         = 1'b0;
        rready          = 1'b0;
        ic_finish_mrd   = 1'b0;
        ic_rdat_m_valid = 1'b0;
        ic_bus_err      = 1'b0;
        ic_fill_busy    = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (icr_start_rq && !rst_pipe) begin
                    addr_d  = ic_rin_addr[31:4];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    drain_d = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                if (rst_pipe) abort_d = 1'b1;
                if (arready)  state_d = DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (rst_pipe) abort_d = 1'b1;
                if (rvalid) begin
                    if (rresp != 2'b00) err_d = 1'b1;
                    // Once four beats are in, surplus beats are consumed but not stored.
                    if (!drain_q) begin
                        case (cnt_q)
                            2'd0: line_d[31:0]   = rdata;
                            2'd1: line_d[63:32]  = rdata;
                            2'd2: line_d[95:64]  = rdata;
                            2'd3: line_d[127:96] = rdata;
                            default: ;
                        endcase
                        cnt_d = cnt_q + 2'd1;
                        if (rlast && (cnt_q != 2'd3)) err_d = 1'b1;
                        if (!rlast && (cnt_q == 2'd3)) begin
                            err_d   = 1'b1;
                            drain_d = 1'b1;
                        end
                    end
                    if (rlast) state_d = DONE;
                end
            end
            DONE: begin
                ic_finish_mrd   = 1'b1;
                ic_bus_err      = err_q;
                ic_rdat_m_valid = !abort_q && !err_q && !rst_pipe;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ic_line_fill.sv
// Directed bench for ic_line_fill: a table of fills driven through a small AXI
// read slave with configurable wait states, plus hand sequences for reset cases.
module tb_ic_line_fill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         icr_start_rq;
    logic [31:0]  ic_rin_addr;
    logic         rst_pipe;
    logic         ic_rdat_m_valid;
    logic [127:0] ic_rdat_m_data;
    logic         ic_finish_mrd;
    logic         ic_fill_busy;
    logic         ic_bus_err;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    int n_cmp = 0;
    int n_bad = 0;

    ic_line_fill #(.IDW(4), .ARID_VAL(4'h1)) dut (
        .clk(clk), .rst_n(rst_n),
        .icr_start_rq(icr_start_rq), .ic_rin_addr(ic_rin_addr), .rst_pipe(rst_pipe),
        .ic_rdat_m_valid(ic_rdat_m_valid), .ic_rdat_m_data(ic_rdat_m_data),
        .ic_finish_mrd(ic_finish_mrd), .ic_fill_busy(ic_fill_busy), .ic_bus_err(ic_bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       addr;
        logic [4:0][31:0]  d;         // beat payloads, index = beat number
        logic [4:0][1:0]   resp;
        int                nb;        // beats sent; rlast on the last one
        int                arw;       // cycles arready held low while arvalid
        int                gap;       // idle cycles before each beat
        int                abort_cyc; // cycle (relative to request) with rst_pipe high, -1 none
        logic [127:0]      exp_data;
        int                exp_valid;
        int                exp_err;
        int                exp_lat;   // cycle of finish pulse relative to request cycle
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        icr_start_rq = 1'b0;
        ic_rin_addr  = '0;
        rst_pipe     = 1'b0;
        arready      = 1'b0;
        rid          = '0;
        rdata        = '0;
        rresp        = '0;
        rlast        = 1'b0;
        rvalid       = 1'b0;
    endtask

    task automatic run_fill(input int idx, input vec_t v);
        int k, arc, gp, b, kfin, nfin, nval, nerr;
        logic [31:0]  exp_ar;
        logic         ar_ok, done;
        logic [127:0] fin_data;
        exp_ar = v.addr & 32'hFFFF_FFF0;
        arc = 0; gp = 0; b = 0; kfin = 0; nfin = 0; nval = 0; nerr = 0;
        ar_ok = 1'b1; done = 1'b0; fin_data = '0;
        @(negedge clk);
        icr_start_rq = 1'b1;
        ic_rin_addr  = v.addr;
        for (k = 1; k <= 120 && !done; k++) begin
            @(negedge clk);
            icr_start_rq = 1'b0;
            rst_pipe     = (k == v.abort_cyc);
            arready      = 1'b0;
            if (arvalid) begin
                if (araddr !== exp_ar) ar_ok = 1'b0;
                arready = (arc >= v.arw);
                arc++;
            end
            rvalid = 1'b0; rlast = 1'b0; rresp = '0; rdata = '0;
            if (rready && b < v.nb) begin
                if (gp < v.gap) gp++;
                else begin
                    rvalid = 1'b1;
                    rdata  = v.d[b];
                    rresp  = v.resp[b];
                    rlast  = (b == v.nb - 1);
                    b++;
                    gp = 0;
                end
            end
            #1;
            if (ic_rdat_m_valid) nval++;
            if (ic_bus_err)      nerr++;
            if (kfin != 0 && k == kfin + 1) begin
                chk($sformatf("t%0d_busy_after_done", idx), 128'(ic_fill_busy), 128'(1'b0));
                done = 1'b1;
            end
            if (ic_finish_mrd) begin
                nfin++;
                if (kfin == 0) begin
                    kfin     = k;
                    fin_data = ic_rdat_m_data;
                end
            end
        end
        idle_inputs();
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL t%0d_timeout: got no completion expected finish by cycle %0d", idx, v.exp_lat);
        end
        chk($sformatf("t%0d_araddr", idx),     128'(ar_ok),   128'(1'b1));
        chk($sformatf("t%0d_latency", idx),    128'(kfin),    128'(v.exp_lat));
        chk($sformatf("t%0d_finish_cnt", idx), 128'(nfin),    128'(1));
        chk($sformatf("t%0d_valid_cnt", idx),  128'(nval),    128'(v.exp_valid));
        chk($sformatf("t%0d_buserr_cnt", idx), 128'(nerr),    128'(v.exp_err));
        chk($sformatf("t%0d_line", idx),       fin_data,      v.exp_data);
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [4:0][31:0] d,
                                input logic [4:0][1:0] resp, input int nb, input int arw,
                                input int gap, input int abort_cyc, input logic [127:0] exp_data,
                                input int exp_valid, input int exp_err, input int exp_lat);
        vec_t v;
        v.addr = addr; v.d = d; v.resp = resp; v.nb = nb; v.arw = arw; v.gap = gap;
        v.abort_cyc = abort_cyc; v.exp_data = exp_data; v.exp_valid = exp_valid;
        v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // nominal fill
        tbl[0] = mk(32'h0000_1238, {32'h0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    '0, 4, 0, 0, -1, 128'h44444444_33333333_22222222_11111111, 1, 0, 6);
        // backpressure: 5 cycles of arready low, 2 idle cycles before each beat
        tbl[1] = mk(32'hDEAD_BEEF, {32'h0, 32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0},
                    '0, 4, 5, 2, -1, 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0, 1, 0, 19);
        // SLVERR on beat 2
        tbl[2] = mk(32'h0000_4000, {32'h0, 32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101},
                    10'b00_00_00_10_00, 4, 0, 0, -1,
                    128'h04040404_03030303_02020202_01010101, 0, 1, 6);
        // rlast on beat 2: upper half keeps the previous line
        tbl[3] = mk(32'h8000_0010, {32'h0, 32'h0, 32'h0, 32'h66666666, 32'h55555555},
                    '0, 2, 0, 0, -1, 128'h04040404_03030303_66666666_55555555, 0, 1, 4);
        // missing rlast on beat 4: fifth beat carries rlast and is not stored
        tbl[4] = mk(32'h0000_0104, {32'h94949494, 32'h93939393, 32'h92929292, 32'h91919191, 32'h90909090},
                    '0, 5, 0, 0, -1, 128'h93939393_92929292_91919191_90909090, 0, 1, 7);
        // rst_pipe pulse after beat 1: drained, no valid
        tbl[5] = mk(32'h0000_2000, {32'h0, 32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1},
                    '0, 4, 0, 0, 3, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1, 0, 0, 6);
        // follow-up normal fill with single wait states
        tbl[6] = mk(32'hFFFF_FFFC, {32'h0, 32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567},
                    '0, 4, 1, 1, -1, 128'h76543210_FEDCBA98_89ABCDEF_01234567, 1, 0, 11);
        // rst_pipe in the DONE cycle suppresses the valid pulse
        tbl[7] = mk(32'h0000_3000, {32'h0, 32'h40404040, 32'h30303030, 32'h20202020, 32'h10101010},
                    '0, 4, 0, 0, 6, 128'h40404040_30303030_20202020_10101010, 0, 0, 6);
        // rst_pipe while arvalid is waiting for arready
        tbl[8] = mk(32'h0000_5550, {32'h0, 32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A},
                    '0, 4, 3, 0, 2, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 0, 0, 9);

        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_arvalid", 128'(arvalid),         128'(1'b0));
        chk("rst_rready",  128'(rready),          128'(1'b0));
        chk("rst_busy",    128'(ic_fill_busy),    128'(1'b0));
        chk("rst_valid",   128'(ic_rdat_m_valid), 128'(1'b0));
        chk("rst_finish",  128'(ic_finish_mrd),   128'(1'b0));
        chk("rst_araddr",  128'(araddr),          128'(32'h0));
        chk("rst_line",    ic_rdat_m_data,        128'h0);
        chk("const_arid",  128'(arid),            128'(4'h1));
        chk("const_arlen", 128'(arlen),           128'(8'd3));
        chk("const_arsize",128'(arsize),          128'(3'b010));
        chk("const_arburst",128'(arburst),        128'(2'b01));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_fill(i, tbl[i]);

        // request and rst_pipe in the same cycle: no burst may start
        @(negedge clk);
        icr_start_rq = 1'b1;
        ic_rin_addr  = 32'h0000_7770;
        rst_pipe     = 1'b1;
        arready      = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            icr_start_rq = 1'b0;
            rst_pipe     = 1'b0;
            #1;
            chk($sformatf("simul_arvalid_c%0d", k), 128'(arvalid),      128'(1'b0));
            chk($sformatf("simul_busy_c%0d", k),    128'(ic_fill_busy), 128'(1'b0));
        end
        idle_inputs();

        // asynchronous reset in the middle of the data phase
        @(negedge clk);
        icr_start_rq = 1'b1;
        ic_rin_addr  = 32'h1234_5670;
        @(negedge clk);
        icr_start_rq = 1'b0;
        arready      = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        chk("arst_pre_rready", 128'(rready), 128'(1'b1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_rready", 128'(rready),          128'(1'b0));
        chk("arst_busy",   128'(ic_fill_busy),    128'(1'b0));
        chk("arst_arvalid",128'(arvalid),         128'(1'b0));
        chk("arst_finish", 128'(ic_finish_mrd),   128'(1'b0));
        chk("arst_araddr", 128'(araddr),          128'(32'h0));
        chk("arst_line",   ic_rdat_m_data,        128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        // a normal fill still works after the async reset
        run_fill(9, tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
